sram_sp_64x128: RTL and testbench

- Synchronous single-port SRAM macro model: 64 words x 128 bits, one read/write port.
- Active-low chip enable and write enable; registered read output.
- Used as the data-array building block of the instruction cache. Each way uses two instances, and address bit 6 selects the instance.
- Stands in for the foundry S011HD1P 64x128 macro.

---
 rtl/sram_sp_64x128_pkg.sv | 5 +
 rtl/sram_sp_64x128.sv | 28 ++
 tb/tb_sram_sp_64x128.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sram_sp_64x128_pkg.sv
// sram_sp_64x128_pkg: geometry of the instruction-cache data-array macro
package sram_sp_64x128_pkg;
    localparam int SRAM_ADDR_W = 6;
    localparam int SRAM_DATA_W = 128;
endpackage

// File: rtl/sram_sp_64x128.sv
// sram_sp_64x128: single-port 64x128 SRAM model, active-low CEN/WEN, registered read, async reset of Q only
module sram_sp_64x128
    import sram_sp_64x128_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              CLK,
    input  logic              rst,
    output logic [DATA_W-1:0] Q,
    input  logic              CEN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic              w_rd;
    logic              w_wr;
    assign w_rd = !CEN && WEN;
    assign w_wr = !CEN && !WEN;
    always_ff @(posedge CLK or posedge rst)
        if (rst) Q <= '0;
        else if (w_rd) Q <= r_mem[A];
    // array is never reset; writes coinciding with rst are dropped
    always_ff @(posedge CLK)
        if (!rst && w_wr) r_mem[A] <= D;
    a_addr_known: assert property (@(posedge CLK) disable iff (rst) !CEN |-> !$isunknown(A));
endmodule

// File: tb/tb_sram_sp_64x128.sv
// tb_sram_sp_64x128: directed plus random checks of the SRAM model against a word-array reference
module tb_sram_sp_64x128;
    logic         CLK = 1'b0;
    logic         rst;
    logic         CEN;
    logic         WEN;
    logic [5:0]   A;
    logic [127:0] D;
    logic [127:0] Q;
    logic [127:0] m_mem [64];
    bit           m_ok  [64];
    logic [127:0] m_q;
    bit           m_q_ok;
    int           checks = 0;
    int           errors = 0;
    localparam logic [127:0] W5   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] ONES = '1;
    localparam logic [127:0] P0   = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] P63  = 128'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
    always #5 CLK = ~CLK;
    sram_sp_64x128 dut (
        .CLK(CLK),
        .rst(rst),
        .Q(Q),
        .CEN(CEN),
        .WEN(WEN),
        .A(A),
        .D(D)
    );
    function automatic logic [127:0] sweep_word(int i);
        logic [31:0] w;
        w = 32'(i * 32'h01010101);
        return {4{w}};
    endfunction
    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // one clock edge: drive at negedge, model the edge, compare 1ns after it
    task automatic op(bit cen, bit wen, logic [5:0] a, logic [127:0] d, string tag);
        CEN = cen;
        WEN = wen;
        A   = a;
        D   = d;
        @(posedge CLK);
        #1;
        if (rst) begin
            m_q    = '0;
            m_q_ok = 1'b1;
        end else if (!cen) begin
            if (wen) begin
                m_q    = m_mem[a];
                m_q_ok = m_ok[a];
            end else begin
                m_mem[a] = d;
                m_ok[a]  = 1'b1;
            end
        end
        if (m_q_ok) check(tag, Q, m_q);
        @(negedge CLK);
    endtask
    initial begin
        for (int i = 0; i < 64; i++) m_ok[i] = 1'b0;
        m_q    = '0;
        m_q_ok = 1'b1;
        rst = 1'b1;
        CEN = 1'b0;
        WEN = 1'b1;
        A   = '0;
        D   = '0;
        #1;
        check("rst_async", Q, '0);
        @(negedge CLK);
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 6'($urandom), '0, "rst_hold");
        rst = 1'b0;
        #1;
        check("rst_release", Q, '0);
        op(1'b1, 1'b1, 6'd0, '0, "idle_after_rst");
        op(1'b0, 1'b0, 6'd5, W5, "wr5_q_hold");
        check("wr5_q_zero", Q, '0);
        op(1'b0, 1'b1, 6'd5, '0, "rd5");
        check("rd5_const", Q, W5);
        op(1'b1, 1'b0, 6'd5, ONES, "cen_hi_q_hold");
        check("cen_hi_q_const", Q, W5);
        op(1'b0, 1'b1, 6'd5, '0, "reread5");
        check("reread5_const", Q, W5);
        for (int i = 0; i < 64; i++) op(1'b0, 1'b0, 6'(i), sweep_word(i), "sweep_wr");
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 6'(i), '0, "sweep_rd");
        check("sweep_last_const", Q, sweep_word(63));
        op(1'b0, 1'b0, 6'd0, P0, "wr0");
        op(1'b0, 1'b0, 6'd63, P63, "wr63");
        op(1'b0, 1'b1, 6'd0, '0, "rd0");
        check("rd0_const", Q, P0);
        op(1'b0, 1'b1, 6'd63, '0, "rd63");
        check("rd63_const", Q, P63);
        op(1'b0, 1'b1, 6'd1, '0, "rd1");
        op(1'b0, 1'b1, 6'd62, '0, "rd62");
        op(1'b0, 1'b1, 6'd32, '0, "rd32");
        for (int i = 10; i < 13; i++) op(1'b0, 1'b1, 6'(i), '0, "burst_rd");
        CEN = 1'b0;
        WEN = 1'b1;
        A   = 6'd13;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_burst", Q, '0);
        m_q    = '0;
        m_q_ok = 1'b1;
        @(negedge CLK);
        op(1'b0, 1'b0, 6'd13, ONES, "wr_during_rst");
        rst = 1'b0;
        op(1'b0, 1'b1, 6'd13, '0, "rd13_after_rst");
        check("rd13_const", Q, sweep_word(13));
        op(1'b0, 1'b1, 6'd12, '0, "rd12_after_rst");
        for (int n = 0; n < 400; n++)
            op($urandom_range(0, 3) == 0, 1'($urandom), 6'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, "random");
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 6'(i), '0, "final_rd");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
